hyper_cfg_seq: RTL and testbench
================================

HYPER_CFG_SEQ -- requirements
Module: hyper_cfg_seq

Interface
REQ-001 SHALL have parameter NumChips, default 2: number of Hyperbus chip-select ranges to program (1..4).
REQ-002 SHALL have parameter ChipBytes, default 8192: bytes per chip range.
REQ-003 SHALL have parameter CfgBase, default 0x4000_0000: Hyperbus config port base address.
REQ-004 SHALL have parameter MemBase, default 0x8000_0000: address of chip 0 range start.
REQ-005 SHALL have parameter MaxRetries, default 3: regbus error retries per access (0..7).
REQ-006 SHALL have parameter AutoStart, default 1: sequence starts on the first cycle after reset release.
REQ-007 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-008 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port start_i, input, 1: one-cycle pulse requesting a (re)programming run.
REQ-010 SHALL have port reg_valid_o, output, 1: regbus request valid.
REQ-011 SHALL have port reg_write_o, output, 1: 1 = write, 0 = read.
REQ-012 SHALL have port reg_addr_o, output, 48: regbus byte address.
REQ-013 SHALL have port reg_wdata_o, output, 32: write data.
REQ-014 SHALL have port reg_wstrb_o, output, 4: byte strobes, 4'hF on writes, 4'h0 on reads.
REQ-015 SHALL have port reg_ready_i, input, 1: regbus response ready; an access completes when valid and ready are both high.
REQ-016 SHALL have port reg_rdata_i, input, 32: read data, valid in the completion cycle.
REQ-017 SHALL have port reg_error_i, input, 1: access error, valid in the completion cycle.
REQ-018 SHALL have port busy_o, output, 1: high while a run is in progress.
REQ-019 SHALL have port done_o, output, 1: sticky, high after a fully verified run.
REQ-020 SHALL have port error_o, output, 1: sticky, high after a failed run.

Function
REQ-021 SHALL program 2*NumChips registers; access index k = 2*i+e, with i = chip and e = 0 for start, 1 for end.
REQ-022 SHALL use address CfgBase + 0x20 + 8*i + 4*e for access k.
REQ-023 SHALL use data MemBase + i*ChipBytes for e=0 and MemBase + (i+1)*ChipBytes for e=1, truncated to 32 bits.
REQ-024 SHALL implement states IDLE, WRITE, READ, DONE, ERR.
REQ-025 SHALL go from IDLE to WRITE with k=0 on start_i, or on the first post-reset cycle when AutoStart=1.
REQ-026 SHALL in WRITE drive valid=1, write=1, and the address and data of access k; on a clean completion at the last k, go to READ with k=0; otherwise increment k.
REQ-027 SHALL in READ drive valid=1, write=0, and the address of access k; on completion compare reg_rdata_i with the expected data; on mismatch go to ERR; on a match at the last k go to DONE, otherwise increment k.
REQ-028 SHALL keep every request signal stable while valid is high and ready is low; valid SHALL NOT drop before completion.
REQ-029 SHALL, on a completion with reg_error_i=1, re-issue the same access from the next cycle and increment the retry count; once the count exceeds MaxRetries, go to ERR; the retry count clears whenever k advances.
REQ-030 SHALL make back-to-back accesses possible: the next access is valid in the cycle after a completion, giving one completion per cycle at most.
REQ-031 SHALL in DONE set done_o=1 and error_o=0, then return to IDLE; in ERR set error_o=1 and done_o=0, then return to IDLE.
REQ-032 SHALL drive busy_o=1 exactly in WRITE and READ.
REQ-033 SHALL ignore start_i while busy_o=1.
REQ-034 SHALL, on a start_i accepted in IDLE, clear done_o and error_o in the same edge that enters WRITE.
REQ-035 SHALL drive reg_valid_o=0 and reg_wstrb_o=0 in IDLE, DONE and ERR.
REQ-036 SHALL have a minimum run latency, from entering WRITE to done_o high, of 4*NumChips+1 cycles when ready is always high.

Reset
REQ-037 SHALL, on rst_i=1 at a clock edge, set state to IDLE, k and the retry count to 0, and busy_o, done_o, error_o and reg_valid_o to 0.
REQ-038 SHALL abandon any in-flight access when reset is asserted mid-run, with no completion required.
REQ-039 SHALL drive reg_addr_o, reg_wdata_o and reg_write_o to 0 while in IDLE.

Verification
REQ-040 SHALL be verified as follows: defaults, ready always 1, reads return written data -> writes 0x4000_0020=0x8000_0000, 0x24=0x8000_2000, 0x28=0x8000_2000, 0x2C=0x8000_4000, then 4 reads, done_o high 9 cycles after WRITE entry.
REQ-041 SHALL be verified as follows: ready held low 5 cycles on the first write -> request held stable for 5 cycles, sequence continues unchanged.
REQ-042 SHALL be verified as follows: reg_error_i=1 on the first 2 completions of write k=1 -> that write issued 3 times, then done_o.
REQ-043 SHALL be verified as follows: reg_error_i=1 on 4 consecutive completions of one access -> error_o=1, busy_o=0, no further valid.
REQ-044 SHALL be verified as follows: read k=3 returns 0x8000_4004 -> error_o=1; a following start_i clears error_o and a clean rerun sets done_o.
REQ-045 SHALL be verified as follows: rst_i asserted during the READ phase -> all outputs 0 next cycle; with AutoStart=1, a new run begins after release.

Source files
------------

// File: rtl/hyper_cfg_seq.sv
// -----------------------------------------------------------------------------
// hyper_cfg_seq
//
// Boot-time sequencer that programs the Hyperbus controller's chip-select
// address ranges over a simple valid/ready register bus. It then reads every
// register back to confirm the values. Each chip i owns two 32-bit registers,
// its range start and its range end. Access k = 2*i + e lives at
// CfgBase + 0x20 + 4*k. A run first writes all 2*NumChips registers in order,
// then reads them back in the same order. Bus errors are retried up to
// MaxRetries times per access. A read-back mismatch, or running out of
// retries, ends the run in the error state.
//
// Parameters
//   NumChips    number of chip-select ranges to program (1..4)
//   ChipBytes   bytes per chip range
//   CfgBase     base address of the Hyperbus config port (48-bit bus)
//   MemBase     address where chip 0's range starts
//   MaxRetries  bus-error retries allowed per access (0..7)
//   AutoStart   1 = begin a run on the first cycle after reset release
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      one-cycle pulse requesting a (re)programming run
//   reg_valid_o  register bus request valid
//   reg_write_o  1 = write, 0 = read
//   reg_addr_o   register bus byte address
//   reg_wdata_o  write data
//   reg_wstrb_o  byte strobes (4'hF on writes, 4'h0 otherwise)
//   reg_ready_i  completion handshake (valid & ready)
//   reg_rdata_i  read data, valid in the completion cycle
//   reg_error_i  access error, valid in the completion cycle
//   busy_o       high while writing or reading back
//   done_o       sticky: last run was fully verified
//   error_o      sticky: last run failed
// -----------------------------------------------------------------------------
module hyper_cfg_seq #(
    parameter int unsigned NumChips   = 2,
    parameter int unsigned ChipBytes  = 8192,
    parameter logic [47:0] CfgBase    = 48'h0000_4000_0000,
    parameter logic [63:0] MemBase    = 64'h0000_0000_8000_0000,
    parameter int unsigned MaxRetries = 3,
    parameter bit          AutoStart  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        reg_valid_o,
    output logic        reg_write_o,
    output logic [47:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic [3:0]  reg_wstrb_o,
    input  logic        reg_ready_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_error_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam logic [2:0]  LastK       = 3'(2 * NumChips - 1);
    localparam logic [3:0]  RetryLimit  = 4'(MaxRetries);
    localparam logic [31:0] MemBase32   = MemBase[31:0];
    localparam logic [31:0] ChipBytes32 = 32'(ChipBytes);
    localparam logic [47:0] RegOffset   = 48'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [2:0]  r_k;          // access index, 2*chip + end_flag
    logic [3:0]  r_retry;      // bus errors seen on the current access
    logic        r_done;
    logic        r_error;
    logic        r_auto_pend;  // one-shot start request left behind by reset

    logic        w_busy;
    logic        w_start;
    logic        w_complete;
    logic        w_last;
    logic        w_retry_out;
    logic [2:0]  w_chip_off;
    logic [31:0] w_exp_data;
    logic [47:0] w_addr;
    logic        w_rdata_ok;

    // -------------------------------------------------------------------------
    // Access decode
    // -------------------------------------------------------------------------
    assign w_busy      = (r_state == S_WRITE) || (r_state == S_READ);
    assign w_start     = start_i || r_auto_pend;
    assign w_complete  = w_busy && reg_ready_i;
    assign w_last      = (r_k == LastK);
    // At the final permitted retry, one more error means the access has failed.
    assign w_retry_out = (r_retry >= RetryLimit);

    // Start register of chip i holds i*ChipBytes and end register holds
    // (i+1)*ChipBytes. Both are covered by the multiplier (k+1)/2.
    assign w_chip_off  = 3'(({1'b0, r_k} + 4'd1) >> 1);
    assign w_exp_data  = MemBase32 + ({29'd0, w_chip_off} * ChipBytes32);
    assign w_addr      = CfgBase + RegOffset + {43'd0, r_k, 2'b00};
    assign w_rdata_ok  = (reg_rdata_i == w_exp_data);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge, whatever the order
    // in which the blocks are evaluated.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the next state gets a default before the case statement. This
    // way every path assigns it and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_complete) begin
                    if (reg_error_i) begin
                        if (w_retry_out) begin
                            w_next_state = S_ERR;
                        end
                    end else if (w_last) begin
                        w_next_state = S_READ;
                    end
                end
            end
            S_READ: begin
                if (w_complete) begin
                    if (reg_error_i) begin
                        if (w_retry_out) begin
                            w_next_state = S_ERR;
                        end
                    end else if (!w_rdata_ok) begin
                        w_next_state = S_ERR;
                    end else if (w_last) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Access index, retry count and sticky status flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_k         <= 3'd0;
            r_retry     <= 4'd0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_auto_pend <= AutoStart;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_k         <= 3'd0;
                        r_retry     <= 4'd0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_auto_pend <= 1'b0;
                    end
                end
                S_WRITE, S_READ: begin
                    if (w_complete) begin
                        if (reg_error_i) begin
                            // Same access is re-issued next cycle. The count
                            // stops at MaxRetries+1 because the FSM leaves.
                            r_retry <= r_retry + 4'd1;
                        end else begin
                            // Last write wraps to k=0 for the read-back pass.
                            r_retry <= 4'd0;
                            r_k     <= w_last ? 3'd0 : r_k + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_error <= 1'b0;
                end
                S_ERR: begin
                    r_error <= 1'b1;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_k <= 3'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The request comes straight from the state and k. Neither changes until
    // a completion, so a stalled request stays stable while ready is low.
    always_comb begin
        reg_valid_o = 1'b0;
        reg_write_o = 1'b0;
        reg_addr_o  = 48'd0;
        reg_wdata_o = 32'd0;
        reg_wstrb_o = 4'h0;
        case (r_state)
            S_WRITE: begin
                reg_valid_o = 1'b1;
                reg_write_o = 1'b1;
                reg_addr_o  = w_addr;
                reg_wdata_o = w_exp_data;
                reg_wstrb_o = 4'hF;
            end
            S_READ: begin
                reg_valid_o = 1'b1;
                reg_addr_o  = w_addr;
            end
            default: begin
                reg_valid_o = 1'b0;
            end
        endcase
    end

    assign busy_o  = w_busy;
    assign done_o  = r_done;
    assign error_o = r_error;

endmodule

// File: tb/tb_hyper_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_hyper_cfg_seq
//
// Directed bench for hyper_cfg_seq with its default parameters. A register-bus
// responder backed by a small memory answers the DUT's requests. Each run
// pushes the expected access list onto a scoreboard queue. Every request cycle
// is compared against the queue head. The head is popped when the access
// completes cleanly.
// -----------------------------------------------------------------------------
module tb_hyper_cfg_seq;

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic        start_i     = 1'b0;
    logic        reg_ready_i = 1'b0;
    logic        reg_error_i = 1'b0;
    logic [31:0] reg_rdata_i = 32'd0;
    logic        reg_valid_o;
    logic        reg_write_o;
    logic [47:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    always #5 clk_i = ~clk_i;

    hyper_cfg_seq dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .reg_valid_o (reg_valid_o),
        .reg_write_o (reg_write_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wstrb_o (reg_wstrb_o),
        .reg_ready_i (reg_ready_i),
        .reg_rdata_i (reg_rdata_i),
        .reg_error_i (reg_error_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    typedef struct packed {
        logic        wr;
        logic [47:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        sb[$];
    logic [31:0] mem [logic [47:0]];
    logic [47:0] exp_addr [4];
    logic [31:0] exp_data [4];

    int          n_cmp = 0;
    int          n_bad = 0;

    // Responder knobs
    int          stall_left   = 0;
    int          stall_seen   = 0;
    int          err_left     = 0;
    int          err_hits     = 0;
    logic [47:0] err_addr     = 48'd0;
    logic        err_write    = 1'b0;
    logic [47:0] corrupt_addr = 48'd0;
    logic [31:0] corrupt_mask = 32'd0;
    int          k1_writes    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected access list of one clean run: 4 writes, then 4 read-backs.
    task automatic push_run();
        sb.delete();
        for (int i = 0; i < 4; i++) sb.push_back(acc_t'{1'b1, exp_addr[i], exp_data[i]});
        for (int i = 0; i < 4; i++) sb.push_back(acc_t'{1'b0, exp_addr[i], exp_data[i]});
    endtask

    // Called just after a falling edge. It checks the current request,
    // drives the response and advances one full clock.
    task automatic bus_cycle();
        logic        rdy;
        logic        err;
        logic [31:0] rd;
        acc_t        head;
        rdy = 1'b1;
        err = 1'b0;
        rd  = 32'd0;
        if (reg_valid_o) begin
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
                stall_seen++;
            end else if (err_left > 0 && reg_addr_o == err_addr && reg_write_o == err_write) begin
                err = 1'b1;
                err_left--;
            end
            if (!reg_write_o) begin
                if (mem.exists(reg_addr_o)) rd = mem[reg_addr_o];
                if (reg_addr_o == corrupt_addr) rd = rd ^ corrupt_mask;
            end
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                head = sb[0];
                check("req_write", 64'(reg_write_o), 64'(head.wr));
                check("req_addr", 64'(reg_addr_o), 64'(head.addr));
                if (head.wr) check("req_wdata", 64'(reg_wdata_o), 64'(head.data));
                check("req_wstrb", 64'(reg_wstrb_o), head.wr ? 64'hF : 64'h0);
                if (rdy && !err) begin
                    if (reg_write_o) mem[reg_addr_o] = reg_wdata_o;
                    void'(sb.pop_front());
                end
            end
            if (rdy && reg_write_o && reg_addr_o == 48'h0000_4000_0024) k1_writes++;
            if (rdy && err) err_hits++;
        end else begin
            check("idle_wstrb", 64'(reg_wstrb_o), 64'd0);
        end
        reg_ready_i = rdy;
        reg_error_i = err;
        reg_rdata_i = rd;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Pulses start_i while the DUT is idle and checks that the run has begun
    // with the sticky flags cleared.
    task automatic start_run();
        push_run();
        start_i = 1'b1;
        bus_cycle();
        start_i = 1'b0;
        check("start_busy", 64'(busy_o), 64'd1);
        check("start_done_clr", 64'(done_o), 64'd0);
        check("start_error_clr", 64'(error_o), 64'd0);
    endtask

    // Runs the bus until done_o or error_o appears. It returns the number of
    // cycles counted from the first busy cycle. It can pulse start_i at one
    // chosen cycle.
    task automatic run_to_end(input int pulse_at, output int cyc);
        cyc = 0;
        while (!(done_o || error_o) && cyc < 100) begin
            start_i = (cyc == pulse_at);
            bus_cycle();
            start_i = 1'b0;
            cyc++;
        end
        check("run_finished", 64'(done_o | error_o), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(reg_valid_o), 64'd0);
        check({tag, "_write"}, 64'(reg_write_o), 64'd0);
        check({tag, "_addr"},  64'(reg_addr_o),  64'd0);
        check({tag, "_wdata"}, 64'(reg_wdata_o), 64'd0);
        check({tag, "_wstrb"}, 64'(reg_wstrb_o), 64'd0);
        check({tag, "_busy"},  64'(busy_o),      64'd0);
        check({tag, "_done"},  64'(done_o),      64'd0);
        check({tag, "_error"}, 64'(error_o),     64'd0);
    endtask

    initial begin
        int cyc;
        int guard;

        exp_addr[0] = 48'h0000_4000_0020; exp_data[0] = 32'h8000_0000;
        exp_addr[1] = 48'h0000_4000_0024; exp_data[1] = 32'h8000_2000;
        exp_addr[2] = 48'h0000_4000_0028; exp_data[2] = 32'h8000_2000;
        exp_addr[3] = 48'h0000_4000_002C; exp_data[3] = 32'h8000_4000;

        // ---- Reset state ----
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");

        // ---- Auto-started clean run: latency 4*NumChips+1 = 9 ----
        rst_i = 1'b0;
        push_run();
        bus_cycle();
        check("auto_busy", 64'(busy_o), 64'd1);
        run_to_end(-1, cyc);
        check("run1_latency", 64'(cyc), 64'd9);
        check("run1_done", 64'(done_o), 64'd1);
        check("run1_error", 64'(error_o), 64'd0);
        check("run1_sb_empty", 64'(sb.size()), 64'd0);

        // ---- Ready held low 5 cycles on the first write ----
        stall_seen = 0;
        stall_left = 5;
        start_run();
        run_to_end(-1, cyc);
        check("stall_cycles", 64'(stall_seen), 64'd5);
        check("stall_latency", 64'(cyc), 64'd14);
        check("stall_done", 64'(done_o), 64'd1);
        check("stall_sb_empty", 64'(sb.size()), 64'd0);

        // ---- Two errors on write k=1, plus a start pulse while busy ----
        k1_writes = 0;
        err_hits  = 0;
        err_addr  = 48'h0000_4000_0024;
        err_write = 1'b1;
        err_left  = 2;
        start_run();
        run_to_end(3, cyc);
        check("retry_k1_issues", 64'(k1_writes), 64'd3);
        check("retry_err_hits", 64'(err_hits), 64'd2);
        check("retry_latency", 64'(cyc), 64'd11);
        check("retry_done", 64'(done_o), 64'd1);
        check("retry_error", 64'(error_o), 64'd0);
        check("retry_sb_empty", 64'(sb.size()), 64'd0);

        // ---- Four errors in a row on write k=2: retries exhausted ----
        err_hits  = 0;
        err_addr  = 48'h0000_4000_0028;
        err_write = 1'b1;
        err_left  = 4;
        start_run();
        run_to_end(-1, cyc);
        check("exhaust_err_hits", 64'(err_hits), 64'd4);
        check("exhaust_error", 64'(error_o), 64'd1);
        check("exhaust_done", 64'(done_o), 64'd0);
        check("exhaust_busy", 64'(busy_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("exhaust_no_valid", 64'(reg_valid_o), 64'd0);
            bus_cycle();
        end
        err_left = 0;

        // ---- Read-back mismatch on k=3 (returns 0x8000_4004) ----
        corrupt_addr = 48'h0000_4000_002C;
        corrupt_mask = 32'h0000_0004;
        start_run();
        run_to_end(-1, cyc);
        check("mismatch_error", 64'(error_o), 64'd1);
        check("mismatch_done", 64'(done_o), 64'd0);
        check("mismatch_busy", 64'(busy_o), 64'd0);
        corrupt_mask = 32'd0;
        start_run();
        run_to_end(-1, cyc);
        check("rerun_done", 64'(done_o), 64'd1);
        check("rerun_error", 64'(error_o), 64'd0);
        check("rerun_latency", 64'(cyc), 64'd9);

        // ---- Reset during the read-back phase, then auto restart ----
        start_run();
        guard = 0;
        while (!(reg_valid_o && !reg_write_o) && guard < 50) begin
            bus_cycle();
            guard++;
        end
        check("reached_read", 64'(reg_valid_o && !reg_write_o), 64'd1);
        bus_cycle();
        rst_i       = 1'b1;
        reg_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("midrst");
        rst_i = 1'b0;
        push_run();
        bus_cycle();
        check("restart_busy", 64'(busy_o), 64'd1);
        run_to_end(-1, cyc);
        check("restart_latency", 64'(cyc), 64'd9);
        check("restart_done", 64'(done_o), 64'd1);
        check("restart_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
